// File: rtl/seg_pkg.sv
// Shared 7-segment definitions: segment width, the ten digit glyphs in the
// same {A,B,C,D,E,F,G} (A = bit 6) encoding the display encoder drives, the
// all-off pattern and the value reported for an unreadable pair.
package seg_pkg;

    localparam int SEG_W = 7;

    localparam logic [SEG_W-1:0] SEG_0     = 7'b1111110;
    localparam logic [SEG_W-1:0] SEG_1     = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_2     = 7'b1101101;
    localparam logic [SEG_W-1:0] SEG_3     = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_4     = 7'b0110011;
    localparam logic [SEG_W-1:0] SEG_5     = 7'b1011011;
    localparam logic [SEG_W-1:0] SEG_6     = 7'b1011111;
    localparam logic [SEG_W-1:0] SEG_7     = 7'b1110000;
    localparam logic [SEG_W-1:0] SEG_8     = 7'b1111111;
    localparam logic [SEG_W-1:0] SEG_9     = 7'b1110011;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;

    localparam logic [6:0] ERR_VALUE = 7'h7F;

    typedef enum logic {
        ST_SETTLE = 1'b0,
        ST_HOLD   = 1'b1
    } settle_state_t;

    // msd*10 + lsd using shifts only; msd,lsd <= 9 keeps the result <= 99.
    function automatic logic [6:0] pair_value(input logic [3:0] msd,
                                              input logic [3:0] lsd);
        logic [6:0] m;
        m = {3'b000, msd};
        return (m << 3) + (m << 1) + {3'b000, lsd};
    endfunction

endpackage

// File: rtl/seg_digit_decode.sv
// Combinational decode of one 7-segment pattern to its digit.
// legal=0 for any pattern that is not one of the ten glyphs; digit is 0 then.
module seg_digit_decode
    import seg_pkg::*;
(
    input  logic [SEG_W-1:0] seg,
    output logic             legal,
    output logic [3:0]       digit
);

    // Exact-match lookup against the glyph table.
    always_comb begin
        legal = 1'b1;
        digit = 4'd0;
        case (seg)
            SEG_0:   digit = 4'd0;
            SEG_1:   digit = 4'd1;
            SEG_2:   digit = 4'd2;
            SEG_3:   digit = 4'd3;
            SEG_4:   digit = 4'd4;
            SEG_5:   digit = 4'd5;
            SEG_6:   digit = 4'd6;
            SEG_7:   digit = 4'd7;
            SEG_8:   digit = 4'd8;
            SEG_9:   digit = 4'd9;
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_pair_reader.sv
// Reads a two-digit 7-segment display back into a binary value 0..99.
// Both buses are synchronized, must hold still for STABLE_CYCLES samples,
// are de-duplicated against the last accepted pair, decoded in one register
// stage and offered through a one-deep valid/ready output register.
//
// Build option SEG_READ_BLANK_MSD_EN: when defined, an all-off tens digit is
// read as 0 (leading-zero blanking). All-off units digit is always an error.
//
// state  | meaning
// -------+-------------------------------------------------------------
// SETTLE | counting consecutive identical samples of the synced pair
// HOLD   | candidate latched; issue to decode if it is a new pattern
module seg_pair_reader
    import seg_pkg::*;
#(
    parameter int STABLE_CYCLES = 16,
    parameter int CNT_W         = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [SEG_W-1:0] seg_msd,
    input  logic [SEG_W-1:0] seg_lsd,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [6:0]       out_value,
    output logic             out_err,
    output logic             overrun
);

    localparam int PAIR_W = 2 * SEG_W;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [PAIR_W-1:0] sync_1;
    logic [PAIR_W-1:0] s;
    logic [PAIR_W-1:0] s_prev;
    logic [PAIR_W-1:0] cand;
    logic [PAIR_W-1:0] last_acc;
    logic              have_last;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_d;
    settle_state_t     state;
    settle_state_t     state_d;
    logic              latch_cand;
    logic              issue;

    logic       msd_legal;
    logic       lsd_legal;
    logic [3:0] msd_digit;
    logic [3:0] lsd_digit;
    logic       msd_ok;
    logic       pair_err;
    logic [6:0] pair_val;

    logic       dec_strobe;
    logic [6:0] dec_value;
    logic       dec_err;

    // Two-flop synchronizer for the combined 14-bit pattern bus.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sync_1 <= '0;
            s      <= '0;
        end else begin
            sync_1 <= {seg_msd, seg_lsd};
            s      <= sync_1;
        end
    end

    // Settle FSM state register.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= ST_SETTLE;
        end else begin
            state <= state_d;
        end
    end

    // Settle FSM next-state, stability counter and control strobes.
    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        latch_cand = 1'b0;
        issue      = 1'b0;
        case (state)
            ST_SETTLE: begin
                if (s != s_prev) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                    if (cnt == CNT_LAST) begin
                        state_d    = ST_HOLD;
                        latch_cand = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                // A repeat of the last accepted pair is dropped silently.
                issue   = !have_last || (cand != last_acc);
                cnt_d   = '0;
                state_d = ST_SETTLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_SETTLE;
            end
        endcase
    end

    // Sample history, counter, candidate and last-accepted tracking.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            s_prev    <= '0;
            cnt       <= '0;
            cand      <= '0;
            last_acc  <= '0;
            have_last <= 1'b0;
        end else begin
            s_prev <= s;
            cnt    <= cnt_d;
            if (latch_cand) begin
                cand <= s;
            end
            if (issue) begin
                last_acc  <= cand;
                have_last <= 1'b1;
            end
        end
    end

    seg_digit_decode u_dec_msd (
        .seg   (cand[PAIR_W-1:SEG_W]),
        .legal (msd_legal),
        .digit (msd_digit)
    );

    seg_digit_decode u_dec_lsd (
        .seg   (cand[SEG_W-1:0]),
        .legal (lsd_legal),
        .digit (lsd_digit)
    );

`ifdef SEG_READ_BLANK_MSD_EN
    // Blank tens digit reads as 0; the decoder already reports digit 0 then.
    assign msd_ok = msd_legal || (cand[PAIR_W-1:SEG_W] == SEG_BLANK);
`else
    assign msd_ok = msd_legal;
`endif

    assign pair_err = !(msd_ok && lsd_legal);
    assign pair_val = pair_err ? ERR_VALUE : pair_value(msd_digit, lsd_digit);

    // Registered decode stage; dec_strobe marks a fresh reading.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            dec_strobe <= 1'b0;
            dec_value  <= '0;
            dec_err    <= 1'b0;
        end else begin
            dec_strobe <= issue;
            if (issue) begin
                dec_value <= pair_val;
                dec_err   <= pair_err;
            end
        end
    end

    // One-deep output register; a reading arriving while full is dropped.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_value <= '0;
            out_err   <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (dec_strobe) begin
                if (!out_valid || out_ready) begin
                    out_valid <= 1'b1;
                    out_value <= dec_value;
                    out_err   <= dec_err;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg_pair_reader.sv
// Bench for seg_pair_reader: a run-length/queue model of the reader checked
// every cycle, plus hand-computed expectations for the directed scenarios.
module tb_seg_pair_reader;
    import seg_pkg::*;

    localparam int N = 16;

    localparam logic [6:0] GLYPH_TAB [10] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
        7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1110011
    };

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [6:0] seg_msd = 7'b0;
    logic [6:0] seg_lsd = 7'b0;
    logic       out_ready = 1'b1;
    logic       out_valid;
    logic [6:0] out_value;
    logic       out_err;
    logic       overrun;

    seg_pair_reader #(.STABLE_CYCLES(N), .CNT_W(8)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .seg_msd   (seg_msd),
        .seg_lsd   (seg_lsd),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_value (out_value),
        .out_err   (out_err),
        .overrun   (overrun)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int t;
        int val;
        int err;
    } arrival_t;

    arrival_t    pend[$];
    int          cyc = 0;
    logic [13:0] m_prev;
    bit          m_have_prev = 0;
    int          m_run = 0;
    logic [13:0] m_last;
    bit          m_have_last = 0;
    bit          exp_valid = 0;
    int          exp_value = 0;
    bit          exp_err = 0;
    bit          exp_overrun = 0;
    bit          model_live = 0;
    logic [13:0] m_smp;
    int          m_v;
    int          m_e;

    function automatic int glyph_digit(input logic [6:0] g);
        for (int i = 0; i < 10; i++) begin
            if (GLYPH_TAB[i] == g) return i;
        end
        return -1;
    endfunction

    task automatic model_decode(input logic [13:0] p, output int val, output int err);
        int m;
        int l;
        m = glyph_digit(p[13:7]);
        l = glyph_digit(p[6:0]);
`ifdef SEG_READ_BLANK_MSD_EN
        if (p[13:7] == 7'b0000000) m = 0;
`endif
        if (m < 0 || l < 0) begin
            val = 127;
            err = 1;
        end else begin
            val = m * 10 + l;
            err = 0;
        end
    endtask

    // A pair sampled identically on N+1 consecutive edges is accepted; a new
    // pair reaches the output register 4 edges later.
    always @(posedge clock) begin
        cyc++;
        if (!reset_n) begin
            pend.delete();
            m_have_prev = 0;
            m_run       = 0;
            m_have_last = 0;
            exp_valid   = 0;
            exp_value   = 0;
            exp_err     = 0;
            exp_overrun = 0;
            model_live  = 1;
        end else begin
            m_smp = {seg_msd, seg_lsd};
            if (m_have_prev && m_smp == m_prev) m_run++;
            else m_run = 1;
            m_prev      = m_smp;
            m_have_prev = 1;
            if (m_run == N + 1 && (!m_have_last || m_smp != m_last)) begin
                model_decode(m_smp, m_v, m_e);
                pend.push_back('{cyc + 4, m_v, m_e});
                m_last      = m_smp;
                m_have_last = 1;
            end
            exp_overrun = 0;
            if (pend.size() > 0 && pend[0].t == cyc) begin
                if (!exp_valid || out_ready) begin
                    exp_valid = 1;
                    exp_value = pend[0].val;
                    exp_err   = pend[0].err != 0;
                end else begin
                    exp_overrun = 1;
                end
                void'(pend.pop_front());
            end else if (out_ready) begin
                exp_valid = 0;
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clock) begin
        if (model_live) begin
            check("cmp out_valid", int'(out_valid), int'(exp_valid));
            check("cmp overrun", int'(overrun), int'(exp_overrun));
            if (exp_valid) begin
                check("cmp out_value", int'(out_value), exp_value);
                check("cmp out_err", int'(out_err), int'(exp_err));
            end
        end
    end

    // Event counters for the directed windows.
    bit prev_valid = 0;
    int rise_cnt = 0;
    int ovr_cnt = 0;
    always @(negedge clock) begin
        if (out_valid === 1'b1 && !prev_valid) rise_cnt++;
        if (overrun === 1'b1) ovr_cnt++;
        prev_valid = (out_valid === 1'b1);
    end

    task automatic wait_valid(input string name, input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (out_valid === 1'b1) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) check({name, " timeout"}, 0, 1);
    endtask

    task automatic apply(input logic [6:0] m, input logic [6:0] l);
        @(negedge clock);
        seg_msd = m;
        seg_lsd = l;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        int t0;
        int at;
        int r0;
        int o0;

        // Reset, then 42 applied on the first released edge.
        reset_n   = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clock);
        check("reset out_valid", int'(out_valid), 0);
        check("reset out_value", int'(out_value), 0);
        check("reset out_err", int'(out_err), 0);
        check("reset overrun", int'(overrun), 0);
        reset_n = 1'b1;
        seg_msd = 7'b0110011;
        seg_lsd = 7'b1101101;
        t0 = cyc + 1;
        wait_valid("first 42", 60, at);
        check("first latency", at - t0, 20);
        check("first value", int'(out_value), 42);
        check("first err", int'(out_err), 0);
        @(negedge clock);
        check("first pulse falls", int'(out_valid), 0);
        repeat (5) @(negedge clock);

        // 99, then held 100 more cycles with no repeat.
        apply(7'b1110011, 7'b1110011);
        wait_valid("99", 60, at);
        check("99 value", int'(out_value), 99);
        @(negedge clock);
        r0 = rise_cnt;
        repeat (100) @(negedge clock);
        check("99 held no repeat", rise_cnt - r0, 0);

        // 42 again (new vs 99), then a short lsd glitch.
        apply(7'b0110011, 7'b1101101);
        wait_valid("42 again", 60, at);
        check("42 again value", int'(out_value), 42);
        repeat (30) @(negedge clock);
        r0 = rise_cnt;
        seg_lsd = 7'b0000000;
        repeat (N - 2) @(negedge clock);
        seg_lsd = 7'b1101101;
        repeat (60) @(negedge clock);
        check("glitch no reading", rise_cnt - r0, 0);

        // Illegal tens digit.
        apply(7'b0000001, 7'b1011011);
        wait_valid("bad msd", 60, at);
        check("bad msd err", int'(out_err), 1);
        check("bad msd value", int'(out_value), 127);
        repeat (5) @(negedge clock);

        // Blank tens digit with 7.
        apply(7'b0000000, 7'b1110000);
        wait_valid("blank msd", 60, at);
`ifdef SEG_READ_BLANK_MSD_EN
        check("blank msd err", int'(out_err), 0);
        check("blank msd value", int'(out_value), 7);
`else
        check("blank msd err", int'(out_err), 1);
        check("blank msd value", int'(out_value), 127);
`endif
        repeat (5) @(negedge clock);

        // Backpressure: 13 held, 57 dropped with one overrun pulse.
        @(negedge clock);
        out_ready = 1'b0;
        seg_msd   = 7'b0110000;
        seg_lsd   = 7'b1111001;
        wait_valid("13", 60, at);
        check("13 value", int'(out_value), 13);
        o0 = ovr_cnt;
        apply(7'b1011011, 7'b1110000);
        repeat (N + 20) @(negedge clock);
        check("57 overrun once", ovr_cnt - o0, 1);
        check("13 still valid", int'(out_valid), 1);
        check("13 held value", int'(out_value), 13);
        out_ready = 1'b1;
        @(negedge clock);
        check("13 consumed", int'(out_valid), 0);
        repeat (5) @(negedge clock);

        // Reset mid-settle with 42 kept applied.
        apply(7'b0110011, 7'b1101101);
        repeat (4) @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        t0 = cyc + 1;
        r0 = rise_cnt;
        wait_valid("post reset 42", 60, at);
        check("post reset latency", at - t0, 20);
        check("post reset value", int'(out_value), 42);
        repeat (N + 30) @(negedge clock);
        check("post reset one reading", rise_cnt - r0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
